// File: rtl/retry_start_pkg.sv
// retry_start_pkg
// Shared definitions for the retry_start block.
//   issue_src_e : selects where the outgoing operation comes from, either the
//                 upstream port (new operation) or the replay table (retry).
// The payload type and ID width stay module parameters, so this package holds
// only items that do not depend on them.
package retry_start_pkg;

  typedef enum logic {
    SRC_UPSTREAM = 1'b0,
    SRC_RETRY    = 1'b1
  } issue_src_e;

endpackage

// File: rtl/retry_start.sv
// retry_start
// Issue side of a retry pair. Every new operation gets an ID. Its payload is
// stored in a table indexed by that ID. When the paired retry_end asks for a
// retry of an ID, the stored payload is re-issued with the same ID ahead of
// any new upstream traffic.
//
// Parameters
//   DataType      : payload type
//   IDSize        : ID width; the table holds 2**IDSize entries
// Ports
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   data_i        : new payload from upstream
//   valid_i       : upstream valid
//   ready_o       : upstream ready
//   data_o        : payload to the operation
//   id_o          : ID sent alongside data_o
//   valid_o       : downstream valid
//   ready_i       : downstream ready
//   retry_id_i    : ID to re-issue, from retry_end
//   retry_valid_i : retry request valid
//   retry_ready_o : retry request accepted
module retry_start
  import retry_start_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o
);

  localparam int unsigned Depth = 2 ** IDSize;

  DataType           entries_q [Depth];
  logic [IDSize-1:0] next_id_q;
  logic [IDSize-1:0] retry_id_q;
  logic              retry_pending_q;

  issue_src_e        issue_src;
  logic              new_xfer;
  logic              retry_accept;

  // A captured retry owns the downstream port until it has been handed over.
  always_comb begin
    issue_src = retry_pending_q ? SRC_RETRY : SRC_UPSTREAM;
  end

  // Output mux. In upstream mode the block is a pass-through that only adds
  // the ID. In retry mode upstream is stalled and the table entry is replayed.
  always_comb begin
    data_o  = data_i;
    valid_o = valid_i;
    id_o    = next_id_q;
    ready_o = ready_i;
    case (issue_src)
      SRC_RETRY: begin
        data_o  = entries_q[retry_id_q];
        valid_o = 1'b1;
        id_o    = retry_id_q;
        ready_o = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Retry acceptance depends on registered state only. This keeps the
  // retry_end -> retry_start return path free of combinational loops, even
  // when the protected operation itself is purely combinational.
  assign retry_ready_o = !retry_pending_q;

  assign new_xfer     = valid_i && ready_i && !retry_pending_q;
  assign retry_accept = retry_valid_i && !retry_pending_q;

  // Control state. Accepting a retry and clearing it are mutually exclusive,
  // because acceptance needs the pending flag low. As a result a fresh retry
  // can start at the earliest one cycle after the previous one drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_id_q       <= '0;
      retry_id_q      <= '0;
      retry_pending_q <= 1'b0;
    end else begin
      if (new_xfer) begin
        next_id_q <= next_id_q + IDSize'(1);
      end
      if (retry_accept) begin
        retry_id_q      <= retry_id_i;
        retry_pending_q <= 1'b1;
      end else if (retry_pending_q && ready_i) begin
        retry_pending_q <= 1'b0;
      end
    end
  end

  // Replay table. It is deliberately not cleared by reset. Only IDs issued
  // after reset are ever replayed, and those entries have been written.
  always_ff @(posedge clk_i) begin
    if (!rst_i && new_xfer) begin
      entries_q[next_id_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_retry_start.sv
module tb_retry_start;

  typedef logic [7:0] data_t;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  data_t          data_i;
  logic           valid_i;
  logic           ready_o;
  data_t          data_o;
  logic [IDW-1:0] id_o;
  logic           valid_o;
  logic           ready_i;
  logic [IDW-1:0] retry_id_i;
  logic           retry_valid_i;
  logic           retry_ready_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  retry_start #(
    .DataType(data_t),
    .IDSize  (IDW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .id_o         (id_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .retry_id_i   (retry_id_i),
    .retry_valid_i(retry_valid_i),
    .retry_ready_o(retry_ready_o)
  );

  // Inputs change 1 time unit after a rising edge and are checked 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input data_t d, input logic r,
                       input logic rv, input logic [IDW-1:0] rid);
    valid_i       = v;
    data_i        = d;
    ready_i       = r;
    retry_valid_i = rv;
    retry_id_i    = rid;
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 8'h5A, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(1, 8'h5A, 0, 0, 0);
    n_cmp++; if (retry_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL reset_retry_ready got=%b exp=1", retry_ready_o); end
    n_cmp++; if (id_o !== 2'd0) begin n_err++; $display("[TB] FAIL reset_id got=%0d exp=0", id_o); end
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL reset_valid_pass got=%b exp=1", valid_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready_pass got=%b exp=0", ready_o); end
    n_cmp++; if (data_o !== 8'h5A) begin n_err++; $display("[TB] FAIL reset_data_pass got=%h exp=5a", data_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, data_t'(8'hA0 + 8'(i) * 8'h10), 1, 0, 0);
      n_cmp++; if (id_o !== 2'(i % DEPTH) || ready_o !== 1'b1) begin
        n_err++; $display("[TB] FAIL b2b_id[%0d] got id=%0d rdy=%b exp id=%0d rdy=1", i, id_o, ready_o, i % DEPTH);
      end
      next_cycle();
    end
    // Replay ID 0 to prove the fifth transfer overwrote it.
    drive(0, 8'h00, 1, 1, 0);
    next_cycle();
    drive(0, 8'h00, 1, 0, 0);
    n_cmp++; if (data_o !== 8'hE0 || id_o !== 2'd0 || valid_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL b2b_wrap_entry got data=%h id=%0d v=%b exp data=e0 id=0 v=1", data_o, id_o, valid_o);
    end
    next_cycle();
  endtask

  task automatic test_retry_stall();
    apply_reset();
    drive(1, 8'h11, 1, 0, 0);
    n_cmp++; if (id_o !== 2'd0) begin n_err++; $display("[TB] FAIL retry_first_id got=%0d exp=0", id_o); end
    next_cycle();
    drive(0, 8'h00, 1, 1, 0);
    n_cmp++; if (retry_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL retry_accept_ready got=%b exp=1", retry_ready_o); end
    next_cycle();
    drive(0, 8'h00, 0, 0, 0);
    n_cmp++; if ({valid_o, data_o, id_o, ready_o, retry_ready_o} !== {1'b1, 8'h11, 2'd0, 1'b0, 1'b0}) begin
      n_err++; $display("[TB] FAIL retry_issue got v=%b d=%h id=%0d rdy=%b rrdy=%b exp v=1 d=11 id=0 rdy=0 rrdy=0",
                        valid_o, data_o, id_o, ready_o, retry_ready_o);
    end
    next_cycle();
    // Hold back the retry. A competing retry request must be ignored meanwhile.
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'hFF, 0, 1, 1);
      n_cmp++; if ({valid_o, data_o, id_o, retry_ready_o} !== {1'b1, 8'h11, 2'd0, 1'b0}) begin
        n_err++; $display("[TB] FAIL retry_stall[%0d] got v=%b d=%h id=%0d rrdy=%b exp v=1 d=11 id=0 rrdy=0",
                          i, valid_o, data_o, id_o, retry_ready_o);
      end
      next_cycle();
    end
    drive(0, 8'h00, 1, 0, 0);
    n_cmp++; if (data_o !== 8'h11 || valid_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL retry_release got d=%h v=%b exp d=11 v=1", data_o, valid_o);
    end
    next_cycle();
    drive(0, 8'h05, 0, 0, 0);
    n_cmp++; if ({retry_ready_o, valid_o, ready_o, data_o} !== {1'b1, 1'b0, 1'b0, 8'h05}) begin
      n_err++; $display("[TB] FAIL retry_cleared got rrdy=%b v=%b rdy=%b d=%h exp rrdy=1 v=0 rdy=0 d=05",
                        retry_ready_o, valid_o, ready_o, data_o);
    end
    next_cycle();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    drive(1, 8'h10, 1, 0, 0);
    next_cycle();
    drive(1, 8'h22, 1, 1, 0);
    n_cmp++; if ({id_o, ready_o, retry_ready_o, valid_o} !== {2'd1, 1'b1, 1'b1, 1'b1}) begin
      n_err++; $display("[TB] FAIL same_cycle_new got id=%0d rdy=%b rrdy=%b v=%b exp id=1 rdy=1 rrdy=1 v=1",
                        id_o, ready_o, retry_ready_o, valid_o);
    end
    next_cycle();
    drive(1, 8'h33, 1, 0, 0);
    n_cmp++; if ({valid_o, data_o, id_o, ready_o} !== {1'b1, 8'h10, 2'd0, 1'b0}) begin
      n_err++; $display("[TB] FAIL same_cycle_retry got v=%b d=%h id=%0d rdy=%b exp v=1 d=10 id=0 rdy=0",
                        valid_o, data_o, id_o, ready_o);
    end
    next_cycle();
    drive(0, 8'h33, 1, 1, 1);
    n_cmp++; if (id_o !== 2'd2) begin n_err++; $display("[TB] FAIL same_cycle_next_id got=%0d exp=2", id_o); end
    next_cycle();
    drive(0, 8'h00, 1, 0, 0);
    n_cmp++; if (data_o !== 8'h22 || id_o !== 2'd1) begin
      n_err++; $display("[TB] FAIL same_cycle_stored got d=%h id=%0d exp d=22 id=1", data_o, id_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_during_retry();
    apply_reset();
    drive(1, 8'h44, 1, 0, 0);
    next_cycle();
    drive(1, 8'h55, 1, 0, 0);
    next_cycle();
    drive(0, 8'h00, 0, 1, 1);
    next_cycle();
    drive(0, 8'h00, 0, 0, 0);
    n_cmp++; if (valid_o !== 1'b1 || data_o !== 8'h55) begin
      n_err++; $display("[TB] FAIL rst_retry_pending got v=%b d=%h exp v=1 d=55", valid_o, data_o);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 0);
    n_cmp++; if ({retry_ready_o, valid_o, id_o} !== {1'b1, 1'b0, 2'd0}) begin
      n_err++; $display("[TB] FAIL rst_retry_dropped got rrdy=%b v=%b id=%0d exp rrdy=1 v=0 id=0",
                        retry_ready_o, valid_o, id_o);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_no_reissue[%0d] got v=%b exp v=0", i, valid_o); end
      next_cycle();
    end
  endtask

  // The bench plays retry_end around a combinational operation that rejects
  // the first attempt of every operation. Each ID must appear exactly twice, in order.
  task automatic test_paired();
    data_t payload [6];
    bit    seen [256];
    int    up_idx = 0;
    int    hs     = 0;
    apply_reset();
    for (int i = 0; i < 6; i++) payload[i] = data_t'(8'h30 + 8'(i));
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int cyc = 0; cyc < 40 && hs < 12; cyc++) begin
      valid_i       = (up_idx < 6);
      data_i        = (up_idx < 6) ? payload[up_idx] : 8'h00;
      ready_i       = 1'b1;
      retry_valid_i = 1'b0;
      retry_id_i    = '0;
      #1;
      retry_valid_i = valid_o && ready_i && !seen[data_o];
      retry_id_i    = id_o;
      #1;
      if (valid_o && ready_i) begin
        n_cmp++; if (id_o !== 2'((hs / 2) % DEPTH) || data_o !== payload[hs / 2]) begin
          n_err++; $display("[TB] FAIL paired_issue[%0d] got id=%0d d=%h exp id=%0d d=%h",
                            hs, id_o, data_o, (hs / 2) % DEPTH, payload[hs / 2]);
        end
        seen[data_o] = 1'b1;
        hs++;
      end
      if (valid_i && ready_o && ready_i) up_idx++;
      next_cycle();
    end
    retry_valid_i = 1'b0;
    n_cmp++; if (hs != 12) begin n_err++; $display("[TB] FAIL paired_timeout got handshakes=%0d exp=12", hs); end
  endtask

  // Random traffic against a transaction-level model: an ID counter modulo
  // DEPTH, a payload memory, and at most one outstanding replay request.
  task automatic test_random();
    int    m_next = 0;
    int    m_mem [DEPTH];
    bit    m_known [DEPTH];
    bit    m_pend = 0;
    int    m_rid  = 0;
    logic  v, r, rv, rs;
    data_t d;
    int    rid;
    logic [12:0] exp_v, got_v;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_known[i] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      v   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      rid = $urandom_range(0, DEPTH - 1);
      rv  = m_known[rid] && ($urandom_range(0, 2) == 0);
      rs  = ($urandom_range(0, 49) == 0);
      rst = rs;
      drive(v, d, r, rv, 2'(rid));
      if (m_pend) exp_v = {1'b1, 1'b0, 1'b0, 2'(m_rid), 8'(m_mem[m_rid])};
      else        exp_v = {v, r, 1'b1, 2'(m_next), d};
      got_v = {valid_o, ready_o, retry_ready_o, id_o, data_o};
      n_cmp++; if (got_v !== exp_v) begin
        n_err++; $display("[TB] FAIL random[%0d] got {v,rdy,rrdy,id,d}=%h exp=%h", c, got_v, exp_v);
      end
      if (rs) begin
        m_next = 0; m_pend = 0; m_rid = 0;
      end else begin
        if (!m_pend && v && r) begin
          m_mem[m_next]   = int'(d);
          m_known[m_next] = 1'b1;
          m_next          = (m_next + 1) % DEPTH;
        end
        if (!m_pend && rv) begin
          m_pend = 1; m_rid = rid;
        end else if (m_pend && r) begin
          m_pend = 0;
        end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    valid_i       = 1'b0;
    data_i        = '0;
    ready_i       = 1'b0;
    retry_valid_i = 1'b0;
    retry_id_i    = '0;
    #1;
    test_reset();
    test_back_to_back();
    test_retry_stall();
    test_same_cycle();
    test_reset_during_retry();
    test_paired();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/retry_start.md
RETRY_START -- requirements
Module: retry_start

Interface
REQ-001 Parameter DataType, default logic, meaning: payload type carried through the protected operation.
REQ-002 Parameter IDSize, default 1, meaning: ID width; table depth is 2**IDSize entries.
REQ-003 clk_i  input  1  meaning: single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  meaning: reset, synchronous, active-high.
REQ-005 data_i  input  DataType  meaning: new operation payload from upstream.
REQ-006 valid_i  input  1  meaning: upstream valid.
REQ-007 ready_o  output  1  meaning: upstream ready.
REQ-008 data_o  output  DataType  meaning: payload to the operation.
REQ-009 id_o  output  IDSize  meaning: ID travelling alongside data_o, under the same handshake, to the paired retry_end.
REQ-010 valid_o  output  1  meaning: downstream valid.
REQ-011 ready_i  input  1  meaning: downstream ready.
REQ-012 retry_id_i  input  IDSize  meaning: ID of the operation to re-issue, from retry_end.
REQ-013 retry_valid_i  input  1  meaning: retry request valid, from retry_end.
REQ-014 retry_ready_o  output  1  meaning: retry request accepted, to retry_end.

Function
REQ-015 A new transfer SHALL occur when valid_i, ready_o and ready_i are all high; retry_pending_q SHALL be low.
REQ-016 With retry_pending_q low: data_o=data_i, valid_o=valid_i, id_o=next_id_q, ready_o=ready_i.
REQ-017 On a new transfer, data_i SHALL be written to table[next_id_q], and next_id_q SHALL increment modulo 2**IDSize (2**IDSize-1 wraps to 0).
REQ-018 retry_ready_o SHALL equal !retry_pending_q and SHALL NOT depend combinationally on ready_i, retry_valid_i or valid_i (no loop through a combinational operation).
REQ-019 When retry_valid_i and retry_ready_o are high, retry_id_q SHALL capture retry_id_i and retry_pending_q SHALL be set on the next edge.
REQ-020 With retry_pending_q high: valid_o=1, data_o=table[retry_id_q], id_o=retry_id_q, ready_o=0; next_id_q and the table SHALL hold.
REQ-021 When retry_pending_q is high and ready_i is high, retry_pending_q SHALL clear on the next edge; a new retry SHALL be accepted no earlier than the following cycle (maximum retry rate one every 2 cycles).
REQ-022 Retries SHALL take priority over new input: a retry captured in cycle N SHALL block new transfers from cycle N+1 until its issue handshake completes.
REQ-023 A retry request and a new transfer in the same cycle SHALL both complete: the new transfer is issued and written, and the retry is captured.
REQ-024 A retried ID SHALL be re-issued with the unchanged stored payload and the same ID, any number of times.
REQ-025 Once asserted, valid_o SHALL stay asserted with data_o and id_o stable until ready_i is high, for both new and retry issues.
REQ-026 The user SHALL keep fewer than 2**IDSize operations in flight; table entries are overwritten on ID wrap without checking.

Reset
REQ-027 While rst_i is high at an edge: next_id_q=0, retry_pending_q=0, retry_id_q=0; table contents SHALL NOT be reset.
REQ-028 After reset: valid_o=valid_i, ready_o=ready_i, retry_ready_o=1, id_o=0.
REQ-029 A reset during a pending retry SHALL drop that retry with no later re-issue.

Structure
REQ-030 No shared package is required; DataType and IDSize SHALL be parameters only, so the block pairs with retry_end for any payload type.
REQ-031 The design SHALL be a single module with no sub-modules; the table SHALL be a register array indexed by ID.

Verification
REQ-032 IDSize=2: issue A,B,C,D,E back-to-back with ready_i=1 -> id_o=0,1,2,3,0; table[0]=E after the 5th transfer.
REQ-033 Issue 0x11 with id 0, then pulse retry_valid_i with retry_id_i=0 -> next cycle valid_o=1, data_o=0x11, id_o=0, ready_o=0, retry_ready_o=0.
REQ-034 Pending retry with ready_i=0 for 3 cycles -> data_o and id_o stable, valid_o=1; ready_i=1 -> retry_pending_q clears; retry_ready_o=1 on the next cycle.
REQ-035 Same-cycle new transfer (id 1, 0x22) and retry request (id 0) -> 0x22 issued and stored; next cycle retry of id 0 issued; next_id_q=2.
REQ-036 Paired with retry_end around a purely combinational operation that flags every first attempt -> no combinational loop in lint or simulation; every ID is issued exactly twice, in order.
REQ-037 Assert rst_i while retry_pending_q=1 -> next cycle retry_pending_q=0, next_id_q=0, retry_ready_o=1; no re-issue of the dropped ID.
